// File: rtl/hub75_rx_capture_if.sv
// HUB75 receive-side bundle: panel pins in, capture-RAM write port and status flags out.
interface hub75_rx_capture_if #(
  parameter int unsigned ROW_BITS   = 5,
  parameter int unsigned ADDR_WIDTH = 12
);
  logic                  data_clock;
  logic                  data_latch;
  logic                  data_blank;
  logic [1:0]            data_r;
  logic [1:0]            data_g;
  logic [1:0]            data_b;
  logic [ROW_BITS-1:0]   row_select;
  logic                  err_clear;
  logic [ADDR_WIDTH-1:0] ram_addr;
  logic [15:0]           ram_data;
  logic                  ram_write_stb;
  logic                  frame_stb;
  logic                  err_count;
  logic                  err_overrun;

  // Panel driver / test harness side.
  modport master (
    output data_clock, data_latch, data_blank, data_r, data_g, data_b, row_select, err_clear,
    input  ram_addr, ram_data, ram_write_stb, frame_stb, err_count, err_overrun
  );

  // Capture block side.
  modport slave (
    input  data_clock, data_latch, data_blank, data_r, data_g, data_b, row_select, err_clear,
    output ram_addr, ram_data, ram_write_stb, frame_stb, err_count, err_overrun
  );
endinterface

// File: rtl/hub75_rx_capture.sv
// HUB75 receiver: rebuilds each displayed row from the panel pins and writes it to a capture RAM
// as {row,col} -> {r,g,b,10'b0}. Shift and hold buffers are separate so the next row can be
// shifted in while the previous one is still waiting for unblank or draining.
module hub75_rx_capture #(
  parameter int unsigned COLS       = 64,
  parameter int unsigned COL_BITS   = 6,
  parameter int unsigned ROW_BITS   = 5,
  parameter int unsigned ADDR_WIDTH = 12
) (
  input logic              clk,
  input logic              rst_n,
  hub75_rx_capture_if.slave bus
);

  // One extra count bit so the counter can sit at COLS+1 when a row is over-clocked.
  localparam int unsigned CntW = COL_BITS + 1;
  localparam logic [CntW-1:0]     ColsCnt = CntW'(COLS);
  localparam logic [CntW-1:0]     SatCnt  = CntW'(COLS + 1);
  localparam logic [COL_BITS-1:0] LastCol = COL_BITS'(COLS - 1);

  typedef enum logic [1:0] {StIdle, StWaitUnblank, StDrain} state_e;

  state_e state_q, state_d;

  logic                clk_q, clk_p, latch_q, latch_p, blank_q, blank_p;
  logic [5:0]          rgb_q;
  logic [ROW_BITS-1:0] row_q;
  logic                clk_rise, latch_rise, blank_fall;

  logic [CntW-1:0]     cnt_q, cnt_shift;
  logic                shift_we;
  logic [COL_BITS-1:0] cnt_idx;
  logic [5:0]          shift_buf [COLS];
  logic [5:0]          hold_buf  [COLS];

  logic                hold_load, set_err_count, set_err_overrun;
  logic [COL_BITS-1:0] col_q;
  logic [ROW_BITS-1:0] drain_row_q;
  logic                frame_q, err_count_q, err_overrun_q;

  // Register the pins once and keep the previous sample for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_q   <= 1'b0;
      clk_p   <= 1'b0;
      latch_q <= 1'b0;
      latch_p <= 1'b0;
      blank_q <= 1'b1;
      blank_p <= 1'b1;
      rgb_q   <= '0;
      row_q   <= '0;
    end else begin
      clk_q   <= bus.data_clock;
      clk_p   <= clk_q;
      latch_q <= bus.data_latch;
      latch_p <= latch_q;
      blank_q <= bus.data_blank;
      blank_p <= blank_q;
      rgb_q   <= {bus.data_r, bus.data_g, bus.data_b};
      row_q   <= bus.row_select;
    end
  end

  assign clk_rise   = clk_q & ~clk_p;
  assign latch_rise = latch_q & ~latch_p;
  assign blank_fall = ~blank_q & blank_p;
  assign shift_we   = clk_rise && (cnt_q < ColsCnt);
  assign cnt_idx    = cnt_q[COL_BITS-1:0];

  // Count after this cycle's shift; the latch check must see it when both edges coincide.
  always_comb begin
    cnt_shift = cnt_q;
    if (clk_rise && (cnt_q != SatCnt)) cnt_shift = cnt_q + 1'b1;
  end

  // Latch acceptance, error detection and state transitions.
  always_comb begin
    state_d         = state_q;
    hold_load       = 1'b0;
    set_err_count   = 1'b0;
    set_err_overrun = 1'b0;
    if (latch_rise) begin
      set_err_count   = (cnt_shift != ColsCnt);
      set_err_overrun = (state_q != StIdle);
      hold_load       = !set_err_count && !set_err_overrun;
    end
    unique case (state_q)
      StIdle:        if (hold_load) state_d = StWaitUnblank;
      StWaitUnblank: if (blank_fall) state_d = StDrain;
      StDrain:       if (col_q == LastCol) state_d = StIdle;
      default:       state_d = StIdle;
    endcase
  end

  // State, drain position, shift count, frame pulse and sticky error flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      col_q         <= '0;
      drain_row_q   <= '0;
      cnt_q         <= '0;
      frame_q       <= 1'b0;
      err_count_q   <= 1'b0;
      err_overrun_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= latch_rise ? '0 : cnt_shift;
      if (state_q == StWaitUnblank && blank_fall) begin
        drain_row_q <= row_q;
        col_q       <= '0;
      end else if (state_q == StDrain) begin
        col_q <= (col_q == LastCol) ? '0 : col_q + 1'b1;
      end
      frame_q <= (state_q == StDrain) && (col_q == LastCol) && (&drain_row_q);
      // A set in the same cycle as a clear wins.
      if (set_err_count)      err_count_q <= 1'b1;
      else if (bus.err_clear) err_count_q <= 1'b0;
      if (set_err_overrun)    err_overrun_q <= 1'b1;
      else if (bus.err_clear) err_overrun_q <= 1'b0;
    end
  end

  // Pixel storage; the hold copy folds in a pixel shifted on the latch cycle itself.
  always_ff @(posedge clk) begin
    if (shift_we) shift_buf[cnt_idx] <= rgb_q;
    if (hold_load) begin
      for (int unsigned i = 0; i < COLS; i++) begin
        hold_buf[i] <= (shift_we && cnt_idx == COL_BITS'(i)) ? rgb_q : shift_buf[i];
      end
    end
  end

  assign bus.ram_write_stb = (state_q == StDrain);
  assign bus.ram_addr      = (state_q == StDrain) ? ADDR_WIDTH'({drain_row_q, col_q}) : '0;
  assign bus.ram_data      = (state_q == StDrain) ? {hold_buf[col_q], 10'b0} : '0;
  assign bus.frame_stb     = frame_q;
  assign bus.err_count     = err_count_q;
  assign bus.err_overrun   = err_overrun_q;

endmodule

// File: tb/tb_hub75_rx_capture.sv
// Bench for hub75_rx_capture: directed HUB75 rows against a row-level model of what the panel
// should have shown, plus literal expectations for latency, last words and error flags.
module tb_hub75_rx_capture;
  localparam int COLS = 64;

  typedef struct packed {
    logic [11:0] addr;
    logic [15:0] data;
  } wr_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  hub75_rx_capture_if #(.ROW_BITS(5), .ADDR_WIDTH(12)) bus ();

  hub75_rx_capture #(.COLS(64), .COL_BITS(6), .ROW_BITS(5), .ADDR_WIDTH(12)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  always @(posedge clk) cyc++;

  // Row-level model: pixels shifted so far, a row latched but not yet shown, and the writes owed.
  int         m_cnt = 0;
  logic [5:0] m_buf  [COLS];
  logic [5:0] m_pend [COLS];
  bit         m_pend_valid = 0;
  bit         m_err_c = 0;
  bit         m_err_o = 0;
  wr_t        exp_q[$];

  // Observation bookkeeping shared with the compare process.
  bit          exp_frame_next = 0;
  bit          in_row = 0;
  int          frames = 0;
  int          row_pops = 0;
  int          first_stb_cyc = -1;
  int          ub_cyc = 0;
  logic [11:0] last_addr = '0;
  logic [15:0] last_data = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic bit busy();
    return m_pend_valid || (exp_q.size() != 0);
  endfunction

  function automatic void model_latch();
    if (m_cnt == COLS && !busy()) begin
      m_pend = m_buf;
      m_pend_valid = 1;
    end else begin
      if (m_cnt != COLS) m_err_c = 1;
      if (busy()) m_err_o = 1;
    end
    m_cnt = 0;
  endfunction

  // Compare every cycle on the falling edge.
  always @(negedge clk) begin
    bit  exp_f;
    wr_t e;
    if (!rst_n) begin
      check("reset_outputs", {bus.ram_addr, bus.ram_data, bus.ram_write_stb, bus.frame_stb,
                              bus.err_count, bus.err_overrun}, 32'h0);
    end else begin
      exp_f = exp_frame_next;
      exp_frame_next = 0;
      check("frame_stb", bus.frame_stb, exp_f);
      if (bus.frame_stb) frames++;
      check("err_count", bus.err_count, m_err_c);
      check("err_overrun", bus.err_overrun, m_err_o);
      if (bus.ram_write_stb) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_write: got addr %0h data %0h, expected no write",
                   bus.ram_addr, bus.ram_data);
        end else begin
          e = exp_q.pop_front();
          check("ram_addr", bus.ram_addr, e.addr);
          check("ram_data", bus.ram_data, e.data);
          if (row_pops == 0) first_stb_cyc = cyc;
          row_pops++;
          last_addr = bus.ram_addr;
          last_data = bus.ram_data;
          in_row = (e.addr[5:0] != 6'd63);
          if (e.addr[5:0] == 6'd63 && e.addr[10:6] == 5'd31) exp_frame_next = 1;
        end
      end else if (in_row) begin
        check("write_gap", bus.ram_write_stb, 1'b1);
        in_row = 0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic shift_px(input logic [5:0] px, input bit with_latch);
    {bus.data_r, bus.data_g, bus.data_b} = px;
    bus.data_clock = 1;
    bus.data_latch = with_latch;
    tick();
    bus.data_clock = 0;
    bus.data_latch = 0;
    tick();
    if (m_cnt < COLS) m_buf[m_cnt] = px;
    m_cnt++;
    if (with_latch) model_latch();
  endtask

  task automatic shift_row(input int n, input int mult, input int add, input int xr);
    for (int k = 0; k < n; k++) shift_px(6'((k * mult + add) ^ xr), 1'b0);
  endtask

  task automatic do_latch();
    bus.data_latch = 1;
    tick();
    bus.data_latch = 0;
    tick();
    model_latch();
  endtask

  task automatic unblank(input logic [4:0] row);
    wr_t w;
    bus.row_select = row;
    bus.data_blank = 0;
    ub_cyc = cyc;
    row_pops = 0;
    if (m_pend_valid) begin
      for (int c = 0; c < COLS; c++) begin
        w.addr = {1'b0, row, 6'(c)};
        w.data = {m_pend[c], 10'b0};
        exp_q.push_back(w);
      end
      m_pend_valid = 0;
    end
    tick();
  endtask

  task automatic wait_drain();
    int i;
    for (i = 0; i < 300; i++) begin
      if (exp_q.size() == 0 && !in_row) break;
      tick();
    end
    if (i == 300) check("drain_timeout", exp_q.size(), 0);
    repeat (4) tick();
    bus.data_blank = 1;
    repeat (3) tick();
  endtask

  task automatic clear_errors();
    bus.err_clear = 1;
    tick();
    bus.err_clear = 0;
    m_err_c = 0;
    m_err_o = 0;
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation still running at 1ms, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int i;
    bus.data_clock = 0;
    bus.data_latch = 0;
    bus.data_blank = 1;
    bus.data_r = '0;
    bus.data_g = '0;
    bus.data_b = '0;
    bus.row_select = '0;
    bus.err_clear = 0;
    repeat (3) tick();
    rst_n = 1;
    repeat (3) tick();

    // Ramp row shown as row 0 (row select moves 31 -> 0 between latch and unblank).
    bus.row_select = 5'd31;
    shift_row(64, 1, 0, 0);
    do_latch();
    unblank(5'd0);
    wait_drain();
    check("unblank_latency", first_stb_cyc - ub_cyc, 2);
    check("ramp_last_addr", last_addr, 12'h03F);
    check("ramp_last_data", last_data, 16'hFC00);
    check("ramp_no_frame", frames, 0);

    // Row 31 ends a frame.
    shift_row(64, 5, 1, 0);
    do_latch();
    unblank(5'd31);
    wait_drain();
    check("row31_last_addr", last_addr, 12'h7FF);
    check("row31_last_data", last_data, 16'hF000);
    check("row31_frame", frames, 1);

    // 64th clock and latch rise together.
    shift_row(63, 1, 0, 6'h2A);
    shift_px(6'(63 ^ 6'h2A), 1'b1);
    unblank(5'd5);
    wait_drain();
    check("same_edge_last_addr", last_addr, 12'h17F);
    check("same_edge_last_data", last_data, 16'h5400);

    // Short row: flagged and discarded.
    shift_row(63, 3, 0, 0);
    do_latch();
    check("short_err_count", bus.err_count, 1'b1);
    unblank(5'd2);
    repeat (10) tick();
    bus.data_blank = 1;
    clear_errors();
    check("short_err_cleared", bus.err_count, 1'b0);

    // Long row: flagged and discarded.
    shift_row(65, 3, 1, 0);
    do_latch();
    check("long_err_count", bus.err_count, 1'b1);
    unblank(5'd3);
    repeat (10) tick();
    bus.data_blank = 1;
    clear_errors();

    // Second latch while the first row waits: overrun, first row still drains intact.
    shift_row(64, 1, 9, 0);
    do_latch();
    tick();
    do_latch();
    check("overrun_flag", bus.err_overrun, 1'b1);
    unblank(5'd7);
    wait_drain();
    check("overrun_row_words", row_pops, 64);
    clear_errors();

    // Reset in the middle of a drain, then a full row again.
    shift_row(64, 7, 2, 0);
    do_latch();
    unblank(5'd9);
    for (i = 0; i < 200; i++) begin
      @(negedge clk);
      #1;
      if (row_pops >= 20) break;
    end
    check("reach_write_20", row_pops, 20);
    rst_n = 0;
    exp_q.delete();
    in_row = 0;
    m_pend_valid = 0;
    m_err_c = 0;
    m_err_o = 0;
    m_cnt = 0;
    exp_frame_next = 0;
    #1;
    check("reset_drops_stb", bus.ram_write_stb, 1'b0);
    bus.data_blank = 1;
    repeat (2) tick();
    rst_n = 1;
    repeat (2) tick();
    shift_row(64, 1, 0, 0);
    do_latch();
    unblank(5'd9);
    wait_drain();
    check("post_reset_words", row_pops, 64);
    check("post_reset_last_addr", last_addr, 12'h27F);
    check("post_reset_last_data", last_data, 16'hFC00);
    check("total_frames", frames, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
